ip2_scan_seq: RTL and testbench

IP2_SCAN_SEQ -- requirements
Module: ip2_scan_seq

---
 rtl/ip2_scan_seq_if.sv | 39 +++
 rtl/ip2_scan_seq.sv | 177 +++++++++++++++++
 tb/tb_ip2_scan_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ip2_scan_seq_if.sv
// Signal bundle between the scan sequencer and its controller: control inputs,
// pattern-register handshake and ASIC scan pins.
interface ip2_scan_seq_if #(
  parameter int DLY_W = 6,
  parameter int CNT_W = 11
);
  logic             enable;
  logic [DLY_W-1:0] clk_counter;
  logic [DLY_W-1:0] test_delay;
  logic             test_mask_reset_not;
  logic             test_start_re;
  logic             test_mode;
  logic             scan_data_bit0;
  logic             scan_out_i;
  logic             o_reg_load;
  logic             o_reg_shift;
  logic             o_capture;
  logic             o_capture_bit;
  logic             o_reset_not;
  logic             o_scan_in;
  logic             o_scan_load;
  logic             o_status_done;
  logic [CNT_W-1:0] o_shift_cnt;
  logic [2:0]       o_state;

  modport master (
    output enable, clk_counter, test_delay, test_mask_reset_not, test_start_re,
           test_mode, scan_data_bit0, scan_out_i,
    input  o_reg_load, o_reg_shift, o_capture, o_capture_bit, o_reset_not,
           o_scan_in, o_scan_load, o_status_done, o_shift_cnt, o_state
  );

  modport slave (
    input  enable, clk_counter, test_delay, test_mask_reset_not, test_start_re,
           test_mode, scan_data_bit0, scan_out_i,
    output o_reg_load, o_reg_shift, o_capture, o_capture_bit, o_reset_not,
           o_scan_in, o_scan_load, o_status_done, o_shift_cnt, o_state
  );
endinterface

// File: rtl/ip2_scan_seq.sv
// Scan-chain sequencer: pulses reset_not, shifts a pattern into the ASIC chain,
// optionally load-compares and shifts the chain back out for readback.
module ip2_scan_seq #(
  parameter int CHAIN_LEN = 1536,
  parameter int DLY_W     = 6,
  parameter int CNT_W     = 11
) (
  input logic            clk,
  input logic            reset,
  ip2_scan_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DELAY     = 3'd1,
    ST_RESET_NOT = 3'd2,
    ST_SHIFT0    = 3'd3,
    ST_SHIFT_IN  = 3'd4,
    ST_LOAD_COMP = 3'd5,
    ST_SHIFT_OUT = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  state_t           state_reg, state_next;
  logic             reset_not_reg, reset_not_next;
  logic             scan_load_reg, scan_load_next;
  logic             scan_in_reg, scan_in_next;
  logic             reg_load_reg, reg_load_next;
  logic             reg_shift_reg, reg_shift_next;
  logic             capture_reg, capture_next;
  logic             capture_bit_reg, capture_bit_next;
  logic             done_reg, done_next;
  logic             mode_reg, mode_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [DLY_W-1:0] strobe_phase;
  logic             tick;
  logic             strobe;
  logic             cnt_full;

  // Strobe sits two phases before tick so the pattern register settles in time.
  assign strobe_phase = bus.test_delay - DLY_W'(2);
  assign tick         = (bus.clk_counter == bus.test_delay);
  assign strobe       = (bus.clk_counter == strobe_phase);
  assign cnt_full     = (cnt_reg >= CNT_W'(CHAIN_LEN));

  always_comb begin
    state_next       = state_reg;
    reset_not_next   = reset_not_reg;
    scan_load_next   = scan_load_reg;
    scan_in_next     = 1'b0;
    reg_shift_next   = 1'b0;
    capture_next     = 1'b0;
    capture_bit_next = capture_bit_reg;
    done_next        = done_reg;
    mode_next        = mode_reg;
    cnt_next         = cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        reset_not_next = 1'b1;
        scan_load_next = 1'b1;
        if (bus.test_start_re) begin
          state_next = ST_DELAY;
          cnt_next   = '0;
          done_next  = 1'b0;
          mode_next  = bus.test_mode;
        end
      end
      ST_DELAY: begin
        if (tick) begin
          state_next     = ST_RESET_NOT;
          reset_not_next = bus.test_mask_reset_not;
        end
      end
      ST_RESET_NOT: begin
        if (tick) begin
          state_next     = ST_SHIFT0;
          reset_not_next = 1'b1;
          scan_load_next = 1'b0;
          scan_in_next   = bus.scan_data_bit0;
        end
      end
      ST_SHIFT0, ST_SHIFT_IN: begin
        scan_load_next = 1'b0;
        scan_in_next   = bus.scan_data_bit0;
        if (strobe && !cnt_full) begin
          reg_shift_next = 1'b1;
          cnt_next       = cnt_reg + CNT_W'(1);
        end
        if (tick) begin
          if (state_reg == ST_SHIFT0) begin
            state_next = ST_SHIFT_IN;
          end else if (cnt_full) begin
            scan_load_next = 1'b1;
            scan_in_next   = 1'b0;
            if (mode_reg) begin
              state_next = ST_LOAD_COMP;
              cnt_next   = '0;
            end else begin
              state_next = ST_DONE;
              done_next  = 1'b1;
            end
          end
        end
      end
      ST_LOAD_COMP: begin
        scan_load_next = 1'b1;
        if (tick) begin
          state_next     = ST_SHIFT_OUT;
          scan_load_next = 1'b0;
        end
      end
      ST_SHIFT_OUT: begin
        scan_load_next = 1'b0;
        if (strobe && !cnt_full) begin
          capture_next     = 1'b1;
          capture_bit_next = bus.scan_out_i;
          cnt_next         = cnt_reg + CNT_W'(1);
        end
        if (tick && cnt_full) begin
          state_next     = ST_DONE;
          scan_load_next = 1'b1;
          done_next      = 1'b1;
        end
      end
      ST_DONE: begin
        state_next     = ST_IDLE;
        reset_not_next = 1'b1;
        scan_load_next = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase

    reg_load_next = (state_next == ST_DELAY);
  end

  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      state_reg       <= ST_IDLE;
      reset_not_reg   <= 1'b1;
      scan_load_reg   <= 1'b1;
      scan_in_reg     <= 1'b0;
      reg_load_reg    <= 1'b0;
      reg_shift_reg   <= 1'b0;
      capture_reg     <= 1'b0;
      capture_bit_reg <= 1'b0;
      done_reg        <= 1'b0;
      mode_reg        <= 1'b0;
      cnt_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      reset_not_reg   <= reset_not_next;
      scan_load_reg   <= scan_load_next;
      scan_in_reg     <= scan_in_next;
      reg_load_reg    <= reg_load_next;
      reg_shift_reg   <= reg_shift_next;
      capture_reg     <= capture_next;
      capture_bit_reg <= capture_bit_next;
      done_reg        <= done_next;
      mode_reg        <= mode_next;
      cnt_reg         <= cnt_next;
    end
  end

  assign bus.o_reg_load    = reg_load_reg;
  assign bus.o_reg_shift   = reg_shift_reg;
  assign bus.o_capture     = capture_reg;
  assign bus.o_capture_bit = capture_bit_reg;
  assign bus.o_reset_not   = reset_not_reg;
  assign bus.o_scan_in     = scan_in_reg;
  assign bus.o_scan_load   = scan_load_reg;
  assign bus.o_status_done = done_reg;
  assign bus.o_shift_cnt   = cnt_reg;
  assign bus.o_state       = state_reg;

endmodule

// File: tb/tb_ip2_scan_seq.sv
// Self-checking bench for ip2_scan_seq: each run is predicted from tick arithmetic
// (tick periods per phase, strobe phase, pattern bit order) and compared per pulse.
module tb_ip2_scan_seq;

  localparam int CL = 8;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  ip2_scan_seq_if #(.DLY_W(6), .CNT_W(4)) bus ();

  ip2_scan_seq #(.CHAIN_LEN(CL), .DLY_W(6), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running phase counter, one count per clk, wraps mod 64.
  initial begin
    bus.clk_counter = '0;
    forever begin
      @(posedge clk);
      #1 bus.clk_counter = bus.clk_counter + 6'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // abort: 0 none, 1 reset after 4th shift, 2 enable low after 4th shift.
  // poke: extra start pulse in SHIFT_IN and test_mode flipped mid-run.
  task automatic run(input string name, input int td, input bit mode, input bit mask,
                     input logic [7:0] pat, input logic [7:0] rb, input int abort,
                     input bit poke);
    int p0, off, shifts, caps, sl_low, rn_low, rises, done_n;
    bit prev_done, ended;
    shifts = 0; caps = 0; sl_low = 0; rn_low = 0; rises = 0; done_n = -1;
    prev_done = 1'b0; ended = 1'b0;
    bus.test_delay          = td[5:0];
    bus.test_mode           = mode;
    bus.test_mask_reset_not = mask;
    bus.scan_data_bit0      = pat[7];
    bus.scan_out_i          = rb[7];
    @(negedge clk);
    bus.test_start_re = 1'b1;
    @(posedge clk);
    p0 = int'(bus.clk_counter);
    #1 bus.test_start_re = 1'b0;
    off = ((td - p0 - 1) & 63) + 1;
    for (int n = 0; n < 1400 && !ended; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk({name, ":delay_state"}, bus.o_state, 1);
        chk({name, ":delay_reg_load"}, bus.o_reg_load, 1);
        chk({name, ":delay_done_clr"}, bus.o_status_done, 0);
        chk({name, ":delay_cnt_clr"}, bus.o_shift_cnt, 0);
      end
      if (bus.o_reg_shift) begin
        chk({name, ":shift_phase"}, (p0 + n) & 63, (td - 2) & 63);
        if (shifts < CL) chk({name, ":scan_in"}, bus.o_scan_in, pat[7 - shifts]);
        shifts++;
        bus.scan_data_bit0 = (shifts < CL) ? pat[7 - shifts] : 1'b0;
        if (abort != 0 && shifts == 4) begin
          if (abort == 1) reset = 1'b1;
          else bus.enable = 1'b0;
          @(negedge clk);
          chk({name, ":abort_state"}, bus.o_state, 0);
          chk({name, ":abort_cnt"}, bus.o_shift_cnt, 0);
          chk({name, ":abort_scan_load"}, bus.o_scan_load, 1);
          chk({name, ":abort_done"}, bus.o_status_done, 0);
          chk({name, ":abort_reset_not"}, bus.o_reset_not, 1);
          chk({name, ":abort_reg_shift"}, bus.o_reg_shift, 0);
          reset = 1'b0;
          bus.enable = 1'b1;
          ended = 1'b1;
        end
      end
      if (!ended) begin
        if (bus.o_capture) begin
          if (caps < CL) chk({name, ":capture_bit"}, bus.o_capture_bit, rb[7 - caps]);
          caps++;
          bus.scan_out_i = (caps < CL) ? rb[7 - caps] : 1'b0;
        end
        if (!bus.o_scan_load) sl_low++;
        if (!bus.o_reset_not) rn_low++;
        if (bus.o_status_done && !prev_done) begin
          rises++;
          done_n = n;
        end
        prev_done = bus.o_status_done;
        if (poke && n == 320) bus.test_start_re = 1'b1;
        if (poke && n == 321) bus.test_start_re = 1'b0;
        if (poke && n == 200) bus.test_mode = ~mode;
        if (rises > 0 && bus.o_state == 3'd0) begin
          ended = 1'b1;
          chk({name, ":end_cnt"}, bus.o_shift_cnt, CL);
          chk({name, ":end_done_held"}, bus.o_status_done, 1);
          chk({name, ":end_scan_load"}, bus.o_scan_load, 1);
          chk({name, ":end_reset_not"}, bus.o_reset_not, 1);
          chk({name, ":end_scan_in"}, bus.o_scan_in, 0);
        end
      end
    end
    bus.test_mode = mode;
    chk({name, ":finished"}, ended, 1);
    if (abort != 0) begin
      chk({name, ":abort_shifts"}, shifts, 4);
    end else begin
      chk({name, ":shifts"}, shifts, CL);
      chk({name, ":captures"}, caps, mode ? CL : 0);
      chk({name, ":scan_load_low"}, sl_low, mode ? 16 * 64 : 8 * 64);
      chk({name, ":reset_not_low"}, rn_low, mask ? 0 : 64);
      chk({name, ":done_rises"}, rises, 1);
      chk({name, ":done_time"}, done_n, off + 64 * (mode ? 18 : 9));
    end
    $display("run %s td=%0d mode=%0d mask=%0d shifts=%0d caps=%0d done_at=%0d",
             name, td, mode, mask, shifts, caps, done_n);
  endtask

  initial begin
    logic [7:0] p, r;
    reset                   = 1'b1;
    bus.enable              = 1'b1;
    bus.test_delay          = 6'd10;
    bus.test_mask_reset_not = 1'b0;
    bus.test_start_re       = 1'b0;
    bus.test_mode           = 1'b0;
    bus.scan_data_bit0      = 1'b0;
    bus.scan_out_i          = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", bus.o_state, 0);
    chk("rst_reset_not", bus.o_reset_not, 1);
    chk("rst_scan_load", bus.o_scan_load, 1);
    chk("rst_scan_in", bus.o_scan_in, 0);
    chk("rst_reg_load", bus.o_reg_load, 0);
    chk("rst_reg_shift", bus.o_reg_shift, 0);
    chk("rst_capture", bus.o_capture, 0);
    chk("rst_capture_bit", bus.o_capture_bit, 0);
    chk("rst_done", bus.o_status_done, 0);
    chk("rst_cnt", bus.o_shift_cnt, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_hold", bus.o_state, 0);

    p = 8'($urandom);
    run("basic",     10, 1'b0, 1'b0, p, 8'h00, 0, 1'b0);
    run("readback",  10, 1'b1, 1'b0, p, 8'b10110010, 0, 1'b0);
    run("masked",    10, 1'b0, 1'b1, 8'($urandom), 8'h00, 0, 1'b0);
    run("td1",        1, 1'b0, 1'b0, 8'($urandom), 8'h00, 0, 1'b0);
    run("td0",        0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 0, 1'b0);
    run("abort_rst", 10, 1'b0, 1'b0, 8'($urandom), 8'h00, 1, 1'b0);
    run("restart",   10, 1'b0, 1'b0, 8'($urandom), 8'h00, 0, 1'b0);
    run("abort_en",  20, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 2, 1'b0);
    run("restart2",  20, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 0, 1'b0);
    run("poke0",     10, 1'b0, 1'b0, 8'($urandom), 8'h00, 0, 1'b1);
    run("poke1",     33, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      p = 8'($urandom);
      r = 8'($urandom);
      run("random", int'($urandom_range(0, 63)), 1'($urandom), 1'($urandom), p, r, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
